wave_capture: RTL and testbench
===============================

# wave_capture

Sample-capture buffer at the receiving end of the waveform generators' 8-bit sample stream. Arms on command, waits for a rising crossing of a programmable level, writes DEPTH consecutive valid samples into internal RAM, then serves them back over a registered read port. Used to snapshot generator output for comparison against the stored tables and for readout.

## Interface
- DEPTH, 1000, number of samples captured per trigger
- AW, 10, address width; 2**AW >= DEPTH
- clk  in  1  sample clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- sample_in  in  8  unsigned sample from a generator
- sample_valid  in  1  sample_in is valid this cycle
- arm  in  1  single-cycle pulse; starts a new capture
- trig_level  in  8  unsigned trigger threshold, sampled every cycle
- rd_en  in  1  read request
- rd_addr  in  AW  read address
- rd_data  out  8  read sample, registered
- rd_valid  out  1  rd_data valid this cycle
- busy  out  1  high in ARMED or CAPTURE
- done  out  1  high in DONE

## Operation
- One clock, clk; reset is asynchronous and active-low on rst_n.
- States: IDLE, ARMED, CAPTURE, DONE.
- IDLE: arm -> ARMED. Other inputs ignored.
- ARMED: prev_ok cleared on entry. Each valid sample: if prev_ok and prev < trig_level and sample_in >= trig_level, trigger: write sample_in to addr 0, wr_ptr <= 1, -> CAPTURE. prev <= sample_in, prev_ok <= 1 on every valid sample. First valid sample after arm cannot trigger.
- CAPTURE: each valid sample written at wr_ptr, wr_ptr increments. Write at wr_ptr == DEPTH-1 -> DONE. Invalid cycles hold wr_ptr; no write.
- DONE: buffer frozen; reads served. arm -> ARMED (done clears).
- arm in ARMED restarts: prev_ok cleared, remains ARMED. arm in CAPTURE ignored.
- Comparison unsigned, 8-bit; trig_level 8'h00 never triggers (no value < 0).
- Read: rd_en honoured only in DONE. rd_addr < DEPTH returns stored sample; rd_addr >= DEPTH returns 8'h00. rd_en outside DONE: rd_valid stays 0, rd_data holds.
- arm and rd_en same cycle in DONE: arm wins, read dropped.
- Captured contents persist after re-arm until overwritten; not cleared by reset (RAM not reset).

## Timing
- Reset: state IDLE, wr_ptr 0, prev 0, prev_ok 0, rd_data 8'h00, rd_valid 0, busy 0, done 0. Reset mid-capture aborts; restart requires new arm.
- arm at edge N: busy high after edge N.
- Trigger sample at edge T: written at T; CAPTURE visible after T.
- Final write at edge F: done high and busy low after F; no gap-free requirement on sample_valid.
- Read latency 1: rd_en/rd_addr at edge R -> rd_data, rd_valid high after R for one cycle; back-to-back reads every cycle.
- Minimum capture: DEPTH valid cycles from trigger to done.

## Test plan
- Reset with rst_n low mid-CAPTURE (no clk edge) -> all outputs 0 immediately, state IDLE; rd_en after release gives rd_valid 0.
- trig_level 8'h80, arm, ramp 0x00..0xFF valid every cycle -> trigger on 0x80; after DEPTH=1000 samples done=1; reading addr 0,1,999 returns 0x80, 0x81, (0x80+999) mod 256 = 0x67.
- Arm while sample_in already 0x90 steady, then 0x70, 0x90 -> no trigger on first 0x90, trigger on second 0x90 (addr 0 = 0x90).
- sample_valid toggling 1/0 during CAPTURE -> done after exactly 1000 valid samples; no invalid data stored; rd_addr 1000 returns 0x00 with rd_valid 1.
- arm during CAPTURE ignored (done still after 1000 samples); arm plus rd_en same cycle in DONE -> rd_valid 0, state ARMED, done 0.
- trig_level 8'h00 with full-range stimulus -> never triggers; busy stays 1, done 0.

Source files
------------

// File: rtl/wave_capture.sv
// Triggered sample-capture buffer for the 8-bit generator stream.
// Arms, waits for a rising level crossing, stores DEPTH samples, serves reads.
module wave_capture #(
  parameter int DEPTH = 1000,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [7:0]    sample_in,
  input  logic          sample_valid,
  input  logic          arm,
  input  logic [7:0]    trig_level,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data,
  output logic          rd_valid,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    CAPTURE,
    DONE
  } state_t;

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  state_t        state;
  state_t        state_nxt;
  logic [AW-1:0] wr_ptr;
  logic [7:0]    prev;
  logic          prev_ok;
  logic          hit;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic          rd_ok;

  logic [7:0]    mem [DEPTH];

  assign hit = sample_valid && prev_ok &&
               (prev < trig_level) &&
               (sample_in >= trig_level);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (arm) state_nxt = ARMED;
      ARMED:   if (!arm && hit) state_nxt = CAPTURE;
      CAPTURE: if (sample_valid && wr_ptr == LAST)
                 state_nxt = DONE;
      DONE:    if (arm) state_nxt = ARMED;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy    = 1'b0;
    done    = 1'b0;
    wr_en   = 1'b0;
    wr_addr = '0;
    rd_ok   = 1'b0;
    unique case (state)
      ARMED: begin
        busy  = 1'b1;
        wr_en = !arm && hit;
      end
      CAPTURE: begin
        busy    = 1'b1;
        wr_en   = sample_valid;
        wr_addr = wr_ptr;
      end
      DONE: begin
        done  = 1'b1;
        rd_ok = rd_en && !arm;
      end
      default: ;
    endcase
  end

  // An arm pulse restarts crossing detection from any non-capture state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      prev    <= '0;
      prev_ok <= 1'b0;
    end else begin
      unique case (state)
        ARMED: begin
          if (arm) begin
            prev_ok <= 1'b0;
          end else if (sample_valid) begin
            prev    <= sample_in;
            prev_ok <= 1'b1;
            if (hit) wr_ptr <= AW'(1);
          end
        end
        CAPTURE: begin
          if (sample_valid) wr_ptr <= wr_ptr + 1'b1;
        end
        default: begin
          if (arm) prev_ok <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= sample_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data  <= 8'h00;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_ok;
      if (rd_ok) begin
        if (rd_addr <= LAST) rd_data <= mem[rd_addr];
        else                 rd_data <= 8'h00;
      end
    end
  end

endmodule

// File: tb/tb_wave_capture.sv
// Scoreboard bench for wave_capture: directed capture scenarios,
// read responses checked by an independent monitor.
module tb_wave_capture;

  localparam int DEPTH = 1000;
  localparam int AW    = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    sample_in = '0;
  logic          sample_valid = 1'b0;
  logic          arm = 1'b0;
  logic [7:0]    trig_level = '0;
  logic          rd_en = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic [7:0]    rd_data;
  logic          rd_valid;
  logic          busy;
  logic          done;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q [$];

  wave_capture #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .sample_in(sample_in),
    .sample_valid(sample_valid),
    .arm(arm),
    .trig_level(trig_level),
    .rd_en(rd_en),
    .rd_addr(rd_addr),
    .rd_data(rd_data),
    .rd_valid(rd_valid),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n && rd_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rd_unexpected: rd_valid=1 data=%h, none required",
                 rd_data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (rd_data !== e) begin
          errors++;
          $display("FAIL rd_data: got %h required %h", rd_data, e);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input bit v, input logic [7:0] s, input bit a);
    sample_valid = v;
    sample_in    = s;
    arm          = a;
    cyc();
    arm          = 1'b0;
    sample_valid = 1'b0;
  endtask

  task automatic rd(input int a, input logic [7:0] e);
    rd_en   = 1'b1;
    rd_addr = AW'(a);
    exp_q.push_back(e);
    cyc();
    rd_en   = 1'b0;
  endtask

  initial begin
    #3;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_rd_valid", rd_valid, 0);
    chk("reset_rd_data", rd_data, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Ramp capture, trigger expected on 0x80
    trig_level = 8'h80;
    put(0, 8'h00, 1);
    chk("ramp_armed_busy", busy, 1);
    for (int i = 0; i < 128; i++) put(1, 8'(i), 0);
    chk("ramp_pre_busy", busy, 1);
    chk("ramp_pre_done", done, 0);
    for (int k = 0; k < DEPTH; k++) begin
      put(1, 8'(8'h80 + k), 0);
      if (k == DEPTH - 2) chk("ramp_done_early", done, 0);
    end
    chk("ramp_done", done, 1);
    chk("ramp_busy_low", busy, 0);
    rd(0, 8'h80);
    rd(1, 8'h81);
    rd(999, 8'h67);
    rd(1000, 8'h00);
    cyc();
    chk("ramp_rd_idle", rd_valid, 0);

    // Steady level at arm cannot trigger; needs a real crossing
    put(1, 8'h90, 1);
    chk("x_busy", busy, 1);
    chk("x_done", done, 0);
    for (int i = 0; i < 3; i++) put(1, 8'h90, 0);
    put(1, 8'h70, 0);
    put(1, 8'h90, 0);
    for (int k = 1; k < DEPTH; k++) begin
      put(1, 8'(k) ^ 8'h5A, k == 500);
      put(0, 8'hEE, 0);
      if (k == DEPTH - 2) chk("gap_done_early", done, 0);
    end
    chk("gap_done", done, 1);
    rd(0, 8'h90);
    rd(1, 8'h5B);
    rd(2, 8'h58);
    rd(500, 8'hAE);
    rd(1000, 8'h00);
    rd(1023, 8'h00);
    rd(999, 8'hBD);

    // Arm beats a same-cycle read in DONE
    arm     = 1'b1;
    rd_en   = 1'b1;
    rd_addr = '0;
    cyc();
    arm     = 1'b0;
    rd_en   = 1'b0;
    chk("armrd_rd_valid", rd_valid, 0);
    chk("armrd_busy", busy, 1);
    chk("armrd_done", done, 0);
    chk("armrd_rd_hold", rd_data, 8'hBD);

    // Zero level never triggers
    trig_level = 8'h00;
    for (int i = 0; i < 512; i++) put(1, 8'(i), 0);
    chk("zero_busy", busy, 1);
    chk("zero_done", done, 0);

    // Asynchronous reset in the middle of a capture
    trig_level = 8'h80;
    put(1, 8'h00, 0);
    put(1, 8'h80, 0);
    for (int i = 0; i < 5; i++) put(1, 8'h01, 0);
    chk("mid_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("async_busy", busy, 0);
    chk("async_done", done, 0);
    chk("async_rd_valid", rd_valid, 0);
    chk("async_rd_data", rd_data, 0);
    @(negedge clk);
    rst_n   = 1'b1;
    rd_en   = 1'b1;
    rd_addr = '0;
    cyc();
    rd_en   = 1'b0;
    chk("post_rst_rd_valid", rd_valid, 0);
    chk("post_rst_idle", busy, 0);
    put(1, 8'h00, 0);
    put(1, 8'hF0, 0);
    chk("idle_ignores", busy, 0);

    cyc();
    chk("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
